// File: rtl/icache_victim_sel.sv
// Icache way allocator for line fills: the lowest invalid way wins, otherwise a victim is
// chosen from per-set tree-PLRU or round-robin state, with a 1-cycle registered result.
module icache_victim_sel #(
   parameter int N_WAY  = 4,
   parameter int N_SETS = 64,
   parameter int MODE   = 0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [$clog2(N_SETS)-1:0]  req_set_i,
   input  logic [N_WAY-1:0]           req_ways_vld_i,
   output logic                       vic_valid_o,
   input  logic                       vic_ready_i,
   output logic [$clog2(N_WAY)-1:0]   vic_way_o,
   output logic [N_WAY-1:0]           vic_onehot_o,
   output logic                       vic_was_inv_o,
   input  logic                       hit_valid_i,
   input  logic [$clog2(N_SETS)-1:0]  hit_set_i,
   input  logic [$clog2(N_WAY)-1:0]   hit_way_i,
   input  logic                       fill_valid_i,
   input  logic [$clog2(N_SETS)-1:0]  fill_set_i,
   input  logic [$clog2(N_WAY)-1:0]   fill_way_i
);

   localparam int WAY_W = $clog2(N_WAY);
   localparam int SW    = (MODE == 0) ? (N_WAY - 1) : WAY_W;

   typedef logic [SW-1:0] st_t;

   st_t                state_q [N_SETS];
   logic               vic_valid_q;
   logic [WAY_W-1:0]   vic_way_q,    vic_way_d;
   logic [N_WAY-1:0]   vic_onehot_q, vic_onehot_d;
   logic               vic_was_inv_q, vic_was_inv_d;
   logic               hit_eff;
   logic               req_fire;
   st_t                fwd_st;
   logic [N_WAY-1:0]   inv_ways;
   logic [WAY_W-1:0]   inv_way;

   // PLRU node n lives in bit n-1; a touch points every node on the way's path away from it.
   function automatic st_t touch(input st_t s, input logic [WAY_W-1:0] w, input logic is_fill);
      st_t r;
      int  n;
      int  p;
      r = s;
      if (MODE == 0) begin
         n = N_WAY + int'(w);
         for (int l = 0; l < WAY_W; l++) begin
            p        = n / 2;
            r[p-1]   = (n % 2 == 0);
            n        = p;
         end
      end else if (is_fill) begin
         r[WAY_W-1:0] = w + WAY_W'(1);
      end
      return r;
   endfunction

   function automatic logic [WAY_W-1:0] pick(input st_t s);
      int n;
      logic [WAY_W-1:0] w;
      if (MODE == 0) begin
         n = 1;
         for (int l = 0; l < WAY_W; l++) begin
            n = 2 * n + int'(s[n-1]);
         end
         w = WAY_W'(n - N_WAY);
      end else begin
         w = s[WAY_W-1:0];
      end
      return w;
   endfunction

   assign req_ready_o = !rst_i && !flush_i && (!vic_valid_q || vic_ready_i);
   assign req_fire    = req_valid_i && req_ready_o;
   assign hit_eff     = hit_valid_i && !(fill_valid_i && (fill_set_i == hit_set_i));

   // Write-first view of the requested set so same-cycle touches steer the choice.
   always_comb begin
      fwd_st = state_q[req_set_i];
      if (hit_eff && (hit_set_i == req_set_i)) begin
         fwd_st = touch(fwd_st, hit_way_i, 1'b0);
      end
      if (fill_valid_i && (fill_set_i == req_set_i)) begin
         fwd_st = touch(fwd_st, fill_way_i, 1'b1);
      end
   end

   always_comb begin
      inv_ways = ~req_ways_vld_i;
      inv_way  = '0;
      for (int i = N_WAY - 1; i >= 0; i--) begin
         if (inv_ways[i]) begin
            inv_way = WAY_W'(i);
         end
      end
      if (inv_ways != '0) begin
         vic_way_d     = inv_way;
         vic_was_inv_d = 1'b1;
      end else begin
         vic_way_d     = pick(fwd_st);
         vic_was_inv_d = 1'b0;
      end
      vic_onehot_d = N_WAY'(1) << vic_way_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         for (int s = 0; s < N_SETS; s++) begin
            state_q[s] <= '0;
         end
      end else begin
         if (fill_valid_i) begin
            state_q[fill_set_i] <= touch(state_q[fill_set_i], fill_way_i, 1'b1);
         end
         if (hit_eff) begin
            state_q[hit_set_i] <= touch(state_q[hit_set_i], hit_way_i, 1'b0);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vic_valid_q   <= 1'b0;
         vic_way_q     <= '0;
         vic_onehot_q  <= '0;
         vic_was_inv_q <= 1'b0;
      end else if (flush_i) begin
         vic_valid_q   <= 1'b0;
      end else if (req_fire) begin
         vic_valid_q   <= 1'b1;
         vic_way_q     <= vic_way_d;
         vic_onehot_q  <= vic_onehot_d;
         vic_was_inv_q <= vic_was_inv_d;
      end else if (vic_ready_i) begin
         vic_valid_q   <= 1'b0;
      end
   end

   assign vic_valid_o   = vic_valid_q;
   assign vic_way_o     = vic_way_q;
   assign vic_onehot_o  = vic_onehot_q;
   assign vic_was_inv_o = vic_was_inv_q;

endmodule

// File: tb/tb_icache_victim_sel.sv
// Directed bench for icache_victim_sel: a PLRU instance and a round-robin instance share
// one set of inputs; each step is checked against hand-computed victims.
module tb_icache_victim_sel;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       req_valid;
   logic [5:0] req_set;
   logic [3:0] req_vld;
   logic       vic_ready;
   logic       hit_valid;
   logic [5:0] hit_set;
   logic [1:0] hit_way;
   logic       fill_valid;
   logic [5:0] fill_set;
   logic [1:0] fill_way;

   logic       rdy0, val0, inv0, rdy1, val1, inv1;
   logic [1:0] way0, way1;
   logic [3:0] oh0, oh1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   icache_victim_sel #(.N_WAY(4), .N_SETS(64), .MODE(0)) u_plru (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(rdy0), .req_set_i(req_set), .req_ways_vld_i(req_vld),
      .vic_valid_o(val0), .vic_ready_i(vic_ready), .vic_way_o(way0), .vic_onehot_o(oh0),
      .vic_was_inv_o(inv0),
      .hit_valid_i(hit_valid), .hit_set_i(hit_set), .hit_way_i(hit_way),
      .fill_valid_i(fill_valid), .fill_set_i(fill_set), .fill_way_i(fill_way)
   );

   icache_victim_sel #(.N_WAY(4), .N_SETS(64), .MODE(1)) u_rr (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(rdy1), .req_set_i(req_set), .req_ways_vld_i(req_vld),
      .vic_valid_o(val1), .vic_ready_i(vic_ready), .vic_way_o(way1), .vic_onehot_o(oh1),
      .vic_was_inv_o(inv1),
      .hit_valid_i(hit_valid), .hit_set_i(hit_set), .hit_way_i(hit_way),
      .fill_valid_i(fill_valid), .fill_set_i(fill_set), .fill_way_i(fill_way)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [5:0] s, input logic [3:0] v);
      req_valid = 1'b1;
      req_set   = s;
      req_vld   = v;
      #1;
      check_eq("req_ready", rdy0, 1'b1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic do_touch(input logic hv, input logic [5:0] hs, input logic [1:0] hw,
                           input logic fv, input logic [5:0] fs, input logic [1:0] fw);
      hit_valid  = hv;
      hit_set    = hs;
      hit_way    = hw;
      fill_valid = fv;
      fill_set   = fs;
      fill_way   = fw;
      step();
      hit_valid  = 1'b0;
      fill_valid = 1'b0;
   endtask

   task automatic expect_plru(input string tag, input logic [1:0] w, input logic inv);
      logic [3:0] oh;
      oh = 4'b0001 << w;
      check_eq({tag, ".valid"}, val0, 1'b1);
      check_eq({tag, ".way"}, way0, w);
      check_eq({tag, ".onehot"}, oh0, oh);
      check_eq({tag, ".was_inv"}, inv0, inv);
   endtask

   task automatic expect_rr(input string tag, input logic [1:0] w);
      logic [3:0] oh;
      oh = 4'b0001 << w;
      check_eq({tag, ".valid"}, val1, 1'b1);
      check_eq({tag, ".way"}, way1, w);
      check_eq({tag, ".onehot"}, oh1, oh);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 1'b1; req_set = 6'd5; req_vld = 4'hF;
      vic_ready = 1'b1; hit_valid = 1'b0; hit_set = '0; hit_way = '0;
      fill_valid = 1'b0; fill_set = '0; fill_way = '0;
      step();
      check_eq("rst.req_ready", rdy0, 1'b0);
      step();
      req_valid = 1'b0;
      rst = 1'b0;
      step();
      check_eq("rst.valid", val0, 1'b0);
      check_eq("rst.way", way0, 2'd0);
      check_eq("rst.onehot", oh0, 4'd0);
      check_eq("rst.was_inv", inv0, 1'b0);

      // invalid way beats policy
      do_req(6'd5, 4'b1011);
      expect_plru("inv", 2'd2, 1'b1);

      // PLRU walk on set 5
      do_req(6'd5, 4'hF);            expect_plru("plru0", 2'd0, 1'b0);
      do_touch(0, 0, 0, 1, 6'd5, 2'd0);
      do_req(6'd5, 4'hF);            expect_plru("plru1", 2'd2, 1'b0);
      do_touch(0, 0, 0, 1, 6'd5, 2'd2);
      do_req(6'd5, 4'hF);            expect_plru("plru2", 2'd1, 1'b0);
      do_touch(0, 0, 0, 1, 6'd5, 2'd1);
      do_req(6'd5, 4'hF);            expect_plru("plru3", 2'd3, 1'b0);

      // backpressure holds the result and blocks requests
      step();
      vic_ready = 1'b0;
      do_req(6'd9, 4'hF);            expect_plru("bp", 2'd0, 1'b0);
      req_valid = 1'b1; req_set = 6'd9; req_vld = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("bp.req_ready", rdy0, 1'b0);
         step();
         expect_plru("bp.hold", 2'd0, 1'b0);
      end
      vic_ready = 1'b1;
      #1;
      check_eq("bp.release_ready", rdy0, 1'b1);
      step();
      req_valid = 1'b0;
      expect_plru("bp.next", 2'd0, 1'b1);

      // same-set hit and fill: only the fill lands
      do_touch(1, 6'd7, 2'd3, 1, 6'd7, 2'd1);
      do_req(6'd7, 4'hF);            expect_plru("hitfill", 2'd2, 1'b0);
      // request forwarded through a same-cycle fill
      fill_valid = 1'b1; fill_set = 6'd7; fill_way = 2'd2;
      do_req(6'd7, 4'hF);
      fill_valid = 1'b0;
      expect_plru("fwd", 2'd0, 1'b0);
      // hit and fill on different sets both land
      do_touch(1, 6'd10, 2'd1, 1, 6'd11, 2'd0);
      do_req(6'd10, 4'hF);           expect_plru("hit_other", 2'd2, 1'b0);
      do_req(6'd11, 4'hF);           expect_plru("fill_other", 2'd2, 1'b0);

      // round-robin pointer on set 0
      do_touch(0, 0, 0, 1, 6'd0, 2'd2);
      do_req(6'd0, 4'hF);            expect_rr("rr0", 2'd3);
      do_touch(0, 0, 0, 1, 6'd0, 2'd3);
      do_req(6'd0, 4'hF);            expect_rr("rr_wrap", 2'd0);
      do_touch(1, 6'd0, 2'd1, 0, 0, 0);
      do_req(6'd0, 4'hF);            expect_rr("rr_hit", 2'd0);
      check_eq("rr.was_inv", inv1, 1'b0);

      // flush drops a stalled result and clears state
      do_touch(0, 0, 0, 1, 6'd5, 2'd0);
      step();
      vic_ready = 1'b0;
      do_req(6'd5, 4'hF);            expect_plru("pre_flush", 2'd3, 1'b0);
      flush = 1'b1; req_valid = 1'b1; req_set = 6'd5; req_vld = 4'hF;
      #1;
      check_eq("flush.req_ready", rdy0, 1'b0);
      step();
      flush = 1'b0; req_valid = 1'b0;
      check_eq("flush.valid", val0, 1'b0);
      vic_ready = 1'b1;
      do_req(6'd5, 4'hF);            expect_plru("post_flush", 2'd0, 1'b0);

      // reset in the middle of a stalled handshake
      step();
      vic_ready = 1'b0;
      do_req(6'd3, 4'b0111);         expect_plru("pre_rst", 2'd3, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      vic_ready = 1'b1;
      check_eq("mid_rst.valid", val0, 1'b0);
      check_eq("mid_rst.way", way0, 2'd0);
      check_eq("mid_rst.onehot", oh0, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
